// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves a carry-save pair (in_a + in_b) into one binary sum using a
// multi-cycle chunked ripple addition. CHUNK bits are resolved per clock, with the carry
// held in a register between chunks, so a result takes NCHUNK = ceil(WIDTH/CHUNK) cycles.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_a/in_b  carry-save operand pair (carry word / sum word)
//   in_valid   operand pair valid
//   in_ready   block can accept a pair (IDLE only, low while rst_n is low)
//   sum        resolved result, (in_a + in_b) mod 2^WIDTH, held after delivery
//   out_valid  sum valid (DONE)
//   out_ready  downstream accepts sum
//   ovf        carry out of bit WIDTH-1 (only when CSA_RESOLVE_OVF_EN is defined)
//
// Optional feature macro: CSA_RESOLVE_OVF_EN adds the ovf output and its flop.

module csa_resolve_seq #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CSA_RESOLVE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NumChunks = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned KWidth    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  // Width of the final (possibly narrow) chunk.
  localparam int unsigned LastW     = WIDTH - (NumChunks - 1) * CHUNK;
  localparam logic [KWidth-1:0] LastK = KWidth'(NumChunks - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [KWidth-1:0]  k_q, k_d;
`ifdef CSA_RESOLVE_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Chunk datapath
  logic [31:0]        chunk_lsb;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic               chunk_carry;
  logic [WIDTH-1:0]   chunk_mask;
  logic [WIDTH-1:0]   chunk_bits;

  always_comb begin
    chunk_lsb = 32'(k_q) * CHUNK;
    // Bits beyond WIDTH shift in as zero, so a narrow last chunk needs no special casing
    // of the operands, only of where its carry out lands.
    a_chunk   = CHUNK'(a_q >> chunk_lsb);
    b_chunk   = CHUNK'(b_q >> chunk_lsb);
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    chunk_carry = (k_q == LastK) ? chunk_sum[LastW] : chunk_sum[CHUNK];
    // Anything shifted past bit WIDTH-1 (including the final carry) falls off here.
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << chunk_lsb;
    chunk_bits = WIDTH'(chunk_sum[CHUNK-1:0]) << chunk_lsb;
  end

  // Next-state and outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    k_d       = k_q;
`ifdef CSA_RESOLVE_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = rst_n;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = 1'b0;
          k_d     = '0;
`ifdef CSA_RESOLVE_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d   = (sum_q & ~chunk_mask) | (chunk_bits & chunk_mask);
        carry_d = chunk_carry;
        k_d     = k_q + 1'b1;
        if (k_q == LastK) begin
`ifdef CSA_RESOLVE_OVF_EN
          ovf_d   = chunk_carry;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
`ifdef CSA_RESOLVE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
`ifdef CSA_RESOLVE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum = sum_q;
`ifdef CSA_RESOLVE_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Bench for csa_resolve_seq: unit 0 at CHUNK=4 (5 chunks), unit 1 at CHUNK=3 (6 chunks).
// A transaction-level model predicts in_ready/out_valid/sum every cycle; directed
// scenarios add literal expectations.
module tb_csa_resolve_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] in_a[2];
  logic [16:0] in_b[2];
  logic        in_valid[2];
  logic        in_ready[2];
  logic [16:0] sum[2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        ovf[2];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  csa_resolve_seq #(.WIDTH(17), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a[0]), .in_b(in_b[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sum(sum[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
`ifdef CSA_RESOLVE_OVF_EN
    , .ovf(ovf[0])
`endif
  );

  csa_resolve_seq #(.WIDTH(17), .CHUNK(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_a(in_a[1]), .in_b(in_b[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sum(sum[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
`ifdef CSA_RESOLVE_OVF_EN
    , .ovf(ovf[1])
`endif
  );

`ifndef CSA_RESOLVE_OVF_EN
  assign ovf[0] = 1'b0;
  assign ovf[1] = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model: a transaction is busy from accept until handshake ----------
  int          nck[2] = '{5, 6};
  bit          busy[2];
  int          age[2];
  logic [16:0] exp_sum[2];
  logic        exp_ovf[2];
  logic [16:0] last_sum[2];
  logic        last_ovf[2];
  int          cyc = 0;
  int          acc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        busy[u]     <= 1'b0;
        age[u]      <= 0;
        last_sum[u] <= '0;
        last_ovf[u] <= 1'b0;
      end else if (busy[u]) begin
        if (age[u] >= nck[u] && out_ready[u]) begin
          busy[u]     <= 1'b0;
          last_sum[u] <= exp_sum[u];
          last_ovf[u] <= exp_ovf[u];
        end else if (age[u] < nck[u]) begin
          age[u] <= age[u] + 1;
        end
      end else if (in_valid[u]) begin
        busy[u] <= 1'b1;
        age[u]  <= 0;
        {exp_ovf[u], exp_sum[u]} <= {1'b0, in_a[u]} + {1'b0, in_b[u]};
        if (u == 1) acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d in_ready", u), 32'(in_ready[u]), 32'(rst_n && !busy[u]));
        check($sformatf("u%0d out_valid", u), 32'(out_valid[u]),
              32'(busy[u] && age[u] >= nck[u]));
        if (busy[u] && age[u] >= nck[u]) begin
          check($sformatf("u%0d sum", u), 32'(sum[u]), 32'(exp_sum[u]));
`ifdef CSA_RESOLVE_OVF_EN
          check($sformatf("u%0d ovf", u), 32'(ovf[u]), 32'(exp_ovf[u]));
`endif
        end else if (!busy[u]) begin
          check($sformatf("u%0d held sum", u), 32'(sum[u]), 32'(last_sum[u]));
`ifdef CSA_RESOLVE_OVF_EN
          check($sformatf("u%0d held ovf", u), 32'(ovf[u]), 32'(last_ovf[u]));
`endif
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int u, output int n);
    n = 0;
    while (!out_valid[u] && n < 30) begin
      step();
      n++;
    end
  endtask

  // Accept a pair on unit 0 then scramble the inputs; returns cycles until out_valid.
  task automatic run0(input logic [16:0] a, input logic [16:0] b, output int lat);
    in_a[0] = a;
    in_b[0] = b;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    in_a[0] = ~a;
    in_b[0] = b ^ 17'h5;
    wait_valid(0, lat);
  endtask

  logic [16:0] pa[2] = '{17'd100, 17'h1F000};
  logic [16:0] pb[2] = '{17'd23, 17'h01234};
  logic [16:0] pr[2] = '{17'd123, 17'h00234};

  initial begin
    int lat;
    int k;
    int r;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_a[u] = '0; in_b[u] = '0; in_valid[u] = 1'b0; out_ready[u] = 1'b1;
    end
    step();
    step();
    chk_en = 1;
    check("reset out_valid", 32'(out_valid[0]), 32'd0);
    check("reset sum", 32'(sum[0]), 32'd0);
    check("reset in_ready", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle in_ready", 32'(in_ready[0]), 32'd1);

    // Carry chain through every chunk
    run0(17'h0FFFF, 17'h00001, lat);
    check("chain latency", 32'(lat), 32'd5);
    check("chain sum", 32'(sum[0]), 32'h10000);
    step();

    // Largest compressor sum
    run0(17'h0AAAA, 17'h09551, lat);
    check("max sum", 32'(sum[0]), 32'h13FFB);
`ifdef CSA_RESOLVE_OVF_EN
    check("max ovf", 32'(ovf[0]), 32'd0);
`endif
    step();

    // Wrap modulo 2^17
    run0(17'h1FFFF, 17'h00001, lat);
    check("wrap sum", 32'(sum[0]), 32'h00000);
`ifdef CSA_RESOLVE_OVF_EN
    check("wrap ovf", 32'(ovf[0]), 32'd1);
`endif
    step();

    // Backpressure with a new pair offered (and ignored) while in DONE
    out_ready[0] = 1'b0;
    run0(17'd5, 17'd6, lat);
    in_valid[0] = 1'b1;
    in_a[0] = 17'd99;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp sum", 32'(sum[0]), 32'd11);
      check("bp out_valid", 32'(out_valid[0]), 32'd1);
      check("bp in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check("bp release out_valid", 32'(out_valid[0]), 32'd0);
    check("bp release in_ready", 32'(in_ready[0]), 32'd1);
    check("bp release sum", 32'(sum[0]), 32'd11);

    // Reset at the second ADD edge
    in_a[0] = 17'h00F0F;
    in_b[0] = 17'h0F0F0;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort out_valid", 32'(out_valid[0]), 32'd0);
    check("abort sum", 32'(sum[0]), 32'd0);
    rst_n = 1'b1;
    step();
    check("abort in_ready", 32'(in_ready[0]), 32'd1);
    run0(17'd3, 17'd4, lat);
    check("post-abort sum", 32'(sum[0]), 32'd7);
    step();

    // Back-to-back on the CHUNK=3 unit
    acc_q.delete();
    k = 0;
    r = 0;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (in_ready[1]) begin
        in_a[1] = pa[k % 2];
        in_b[1] = pb[k % 2];
        k++;
      end
      step();
      if (out_valid[1]) begin
        check("b2b sum", 32'(sum[1]), 32'(pr[r % 2]));
        r++;
      end
    end
    in_valid[1] = 1'b0;
    check("b2b results", 32'(r >= 5), 32'd1);
    for (int i = 1; i < acc_q.size(); i++) begin
      check("b2b interval", 32'(acc_q[i] - acc_q[i-1]), 32'd8);
    end
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
